// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Round-robin arbiter sharing one sdram_core_32bit command interface among
//   NPORTS requesters. One command is presented to the core at a time; the
//   core's accept is routed back to the granted port. Accepted reads push the
//   issuing port number into an in-order tag FIFO so each core ack (and its
//   read data) is steered back to the right port.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_addr/req_wdata         per-port address / write data, flattened
//   req_wr/req_rd              per-port command requests, held until accepted
//   req_accept                 one-hot: core took that port's command
//   req_ack/req_rdata          one-hot read completion + broadcast data
//   core_*                     command/response interface to sdram_core_32bit
//   busy                       command in flight or reads outstanding
//   err_spur_ack               sticky: core acked with no read outstanding
module sdram_port_arbiter #(
    parameter int NPORTS       = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    input  logic [NPORTS-1:0]        req_wr,
    input  logic [NPORTS-1:0]        req_rd,
    output logic [NPORTS-1:0]        req_accept,
    output logic [NPORTS-1:0]        req_ack,
    output logic [DATA_W-1:0]        req_rdata,
    output logic [ADDR_W-1:0]        core_addr,
    output logic [DATA_W-1:0]        core_wdata,
    output logic                     core_wr,
    output logic                     core_rd,
    input  logic                     core_accept,
    input  logic                     core_ack,
    input  logic [DATA_W-1:0]        core_rdata,
    output logic                     busy,
    output logic                     err_spur_ack
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int FW = (MAX_RD_OUTST > 1) ? $clog2(MAX_RD_OUTST) : 1;
    localparam int CW = $clog2(MAX_RD_OUTST + 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     rr_ptr, gnt, sel;
    logic              gnt_is_wr, found;
    logic [NPORTS-1:0] elig;
    logic              cmd, accept, push, pop;

    logic [PW-1:0]     fifo_mem [MAX_RD_OUTST];
    logic [FW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              fifo_full, fifo_empty;
    logic [PW-1:0]     head;

    assign fifo_full  = (count == CW'(MAX_RD_OUTST));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Reads are held off while the tag FIFO is full; writes never are.
    for (genvar p = 0; p < NPORTS; p++) begin : g_elig
        assign elig[p] = req_wr[p] | (req_rd[p] & ~fifo_full);
    end

    // First eligible port at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Command mux: qualified by the live request so a dropped request
    // disappears from the core in the same cycle.
    always_comb begin
        core_addr  = '0;
        core_wdata = '0;
        core_wr    = 1'b0;
        core_rd    = 1'b0;
        if (state == ISSUE) begin
            core_addr  = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
            core_wdata = req_wdata[int'(gnt)*DATA_W +: DATA_W];
            core_wr    = gnt_is_wr & req_wr[gnt];
            core_rd    = ~gnt_is_wr & req_rd[gnt];
        end
    end

    assign cmd    = core_wr | core_rd;
    assign accept = core_accept & cmd;
    assign push   = accept & ~gnt_is_wr;
    assign pop    = core_ack & ~fifo_empty;

    always_comb begin
        req_accept = '0;
        req_ack    = '0;
        if (accept) req_accept[gnt] = 1'b1;
        if (pop)    req_ack[head]   = 1'b1;
    end

    assign req_rdata = pop ? core_rdata : '0;
    assign busy      = (state == ISSUE) | ~fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   if (!cmd || accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt          <= '0;
            gnt_is_wr    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_spur_ack <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                gnt       <= sel;
                gnt_is_wr <= req_wr[sel];
            end
            if (accept)
                rr_ptr <= (gnt == PW'(NPORTS - 1)) ? '0 : gnt + PW'(1);
            if (push)
                wr_ptr <= (wr_ptr == FW'(MAX_RD_OUTST - 1)) ? '0 : wr_ptr + FW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == FW'(MAX_RD_OUTST - 1)) ? '0 : rd_ptr + FW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (core_ack && fifo_empty) err_spur_ack <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= gnt;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]  req_wr, req_rd, req_accept, req_ack;
    logic [DW-1:0]  req_rdata, core_wdata, core_rdata;
    logic [AW-1:0]  core_addr;
    logic           core_wr, core_rd, core_accept, core_ack, busy, err_spur_ack;

    int errors = 0;
    int checks = 0;

    sdram_port_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_RD_OUTST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wr(req_wr), .req_rd(req_rd),
        .req_accept(req_accept), .req_ack(req_ack), .req_rdata(req_rdata),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_wr(core_wr), .core_rd(core_rd),
        .core_accept(core_accept), .core_ack(core_ack), .core_rdata(core_rdata),
        .busy(busy), .err_spur_ack(err_spur_ack)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after the rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_wr = '0; req_rd = '0; core_accept = 1'b0; core_ack = 1'b0; core_rdata = '0;
        req_addr = '0; req_wdata = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_wr = '0; req_rd = '0; core_accept = 1'b0; core_ack = 1'b0;
        req_addr = '0; req_wdata = '0; core_rdata = '0;
        #3;
        checks++;
        if ({core_wr, core_rd, busy, err_spur_ack, req_accept, req_ack} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b rd=%b busy=%b err=%b acc=%b ack=%b exp all 0",
                     core_wr, core_rd, busy, err_spur_ack, req_accept, req_ack);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_port();
        do_reset();
        core_accept = 1'b1;
        req_addr[0 +: AW] = 32'h100;
        req_wdata[0 +: DW] = 32'hDEADBEEF;
        req_wr = 4'b0001;
        cyc();
        checks++;
        if (core_wr !== 1'b1 || core_rd !== 1'b0 || core_addr !== 32'h100 ||
            core_wdata !== 32'hDEADBEEF || req_accept !== 4'b0001) begin
            errors++;
            $display("FAIL single_wr: got wr=%b rd=%b addr=%h data=%h acc=%b exp 1 0 100 deadbeef 0001",
                     core_wr, core_rd, core_addr, core_wdata, req_accept);
        end
        cyc();
        req_wr = '0; req_rd = 4'b0001;
        checks++;
        if (core_wr !== 1'b0 || core_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got wr=%b rd=%b exp 0 0", core_wr, core_rd);
        end
        cyc();
        checks++;
        if (core_rd !== 1'b1 || req_accept !== 4'b0001) begin
            errors++;
            $display("FAIL single_rd: got rd=%b acc=%b exp 1 0001", core_rd, req_accept);
        end
        cyc();
        req_rd = '0;
        checks++;
        if (busy !== 1'b1 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_outst: got busy=%b ack=%b exp 1 0000", busy, req_ack);
        end
        core_ack = 1'b1; core_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ack !== 4'b0001 || req_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_ack: got ack=%b data=%h exp 0001 deadbeef", req_ack, req_rdata);
        end
        cyc();
        core_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || err_spur_ack !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got busy=%b err=%b exp 0 0", busy, err_spur_ack);
        end
    endtask

    task automatic test_all_ports_rd();
        do_reset();
        core_accept = 1'b1;
        req_rd = 4'b1111;
        for (int k = 0; k < NP; k++) begin
            cyc();
            checks++;
            if (req_accept !== 4'(1 << k) || core_rd !== 1'b1) begin
                errors++;
                $display("FAIL rr_order[%0d]: got acc=%b rd=%b exp %b 1", k, req_accept, core_rd, 4'(1 << k));
            end
            cyc();
            req_rd[k] = 1'b0;
        end
        for (int k = 0; k < NP; k++) begin
            core_ack = 1'b1; core_rdata = 32'hA0 + k;
            #1;
            checks++;
            if (req_ack !== 4'(1 << k) || req_rdata !== 32'hA0 + k) begin
                errors++;
                $display("FAIL ack_order[%0d]: got ack=%b data=%h exp %b %h",
                         k, req_ack, req_rdata, 4'(1 << k), 32'hA0 + k);
            end
            cyc();
        end
        core_ack = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL all_drain: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_rotation();
        int exp_p;
        do_reset();
        core_accept = 1'b1;
        req_wr = 4'b0101; req_rd = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            exp_p = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 1 : 2;
            cyc();
            core_ack = 1'b0;
            #1;
            checks++;
            if (req_accept !== 4'(1 << exp_p)) begin
                errors++;
                $display("FAIL rotate[%0d]: got acc=%b exp %b", k, req_accept, 4'(1 << exp_p));
            end
            cyc();
            if (exp_p == 1) begin
                core_ack = 1'b1; core_rdata = 32'h5000 + k;
                #1;
                checks++;
                if (req_ack !== 4'b0010 || req_rdata !== 32'h5000 + k) begin
                    errors++;
                    $display("FAIL rotate_ack[%0d]: got ack=%b data=%h exp 0010 %h",
                             k, req_ack, req_rdata, 32'h5000 + k);
                end
            end
        end
        req_wr = '0; req_rd = '0; core_ack = 1'b0;
        cyc();
    endtask

    task automatic test_fifo_full();
        do_reset();
        core_accept = 1'b1;
        req_rd = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (req_accept !== 4'b0010) begin
                errors++;
                $display("FAIL fill[%0d]: got acc=%b exp 0010", k, req_accept);
            end
            cyc();
        end
        cyc();
        checks++;
        if (core_rd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_block: got rd=%b busy=%b exp 0 1", core_rd, busy);
        end
        req_wr = 4'b1000;
        cyc();
        checks++;
        if (req_accept !== 4'b1000 || core_wr !== 1'b1) begin
            errors++;
            $display("FAIL full_wr: got acc=%b wr=%b exp 1000 1", req_accept, core_wr);
        end
        cyc();
        req_wr = '0;
        cyc();
        checks++;
        if (core_rd !== 1'b0) begin
            errors++;
            $display("FAIL full_still: got rd=%b exp 0", core_rd);
        end
        core_ack = 1'b1; core_rdata = 32'h11;
        #1;
        checks++;
        if (req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL full_ack: got ack=%b exp 0010", req_ack);
        end
        cyc();
        core_ack = 1'b0;
        cyc();
        checks++;
        if (req_accept !== 4'b0010) begin
            errors++;
            $display("FAIL full_free: got acc=%b exp 0010", req_accept);
        end
        cyc();
        req_rd = '0;
        for (int k = 0; k < 4; k++) begin
            core_ack = 1'b1;
            #1;
            checks++;
            if (req_ack !== 4'b0010) begin
                errors++;
                $display("FAIL full_drain[%0d]: got ack=%b exp 0010", k, req_ack);
            end
            cyc();
        end
        core_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || err_spur_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_end: got busy=%b err=%b exp 0 0", busy, err_spur_ack);
        end
    endtask

    task automatic test_spur_ack();
        core_ack = 1'b1;
        #1;
        checks++;
        if (req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL spur_noack: got ack=%b exp 0000", req_ack);
        end
        cyc();
        core_ack = 1'b0;
        checks++;
        if (err_spur_ack !== 1'b1) begin
            errors++;
            $display("FAIL spur_set: got err=%b exp 1", err_spur_ack);
        end
        cyc(); cyc();
        checks++;
        if (err_spur_ack !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: got err=%b exp 1", err_spur_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_spur_ack !== 1'b0) begin
            errors++;
            $display("FAIL spur_clear: got err=%b exp 0", err_spur_ack);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_drop();
        do_reset();
        core_accept = 1'b0;
        req_rd = 4'b0100;
        cyc();
        checks++;
        if (core_rd !== 1'b1 || req_accept !== 4'b0000) begin
            errors++;
            $display("FAIL drop_issue: got rd=%b acc=%b exp 1 0000", core_rd, req_accept);
        end
        cyc();
        req_rd = 4'b0000;
        #1;
        checks++;
        if (core_rd !== 1'b0) begin
            errors++;
            $display("FAIL drop_fall: got rd=%b exp 0", core_rd);
        end
        cyc();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got busy=%b exp 0", busy);
        end
        // rr_ptr still 0, so port 1 wins over port 3.
        core_accept = 1'b1;
        req_rd = 4'b1010;
        cyc();
        checks++;
        if (req_accept !== 4'b0010) begin
            errors++;
            $display("FAIL drop_rrptr: got acc=%b exp 0010", req_accept);
        end
        cyc();
        req_rd = '0;
        core_ack = 1'b1;
        cyc();
        core_ack = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_all_ports_rd();
        test_rotation();
        test_fifo_full();
        test_spur_ack();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
